// File: rtl/sensor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sensor_pkg : request/response codes and FSM states for sensor_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package sensor_pkg;

  localparam logic [7:0] c_REQ_STATUS  = 8'h00;
  localparam logic [7:0] c_REQ_TEMP    = 8'h02;
  localparam logic [7:0] c_REQ_HUM     = 8'h03;
  localparam logic [7:0] c_RSP_CKSUM   = 8'h1F;
  localparam logic [7:0] c_RSP_TIMEOUT = 8'h2F;
  localparam logic [7:0] c_RSP_BADCODE = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_WAIT_GAP = 3'd2,
    ST_READ     = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_RESP     = 3'd5
  } sched_state_e;

  function automatic logic is_data_req(input logic [7:0] code);
    return (code == c_REQ_TEMP) || (code == c_REQ_HUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sched_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sched_sat_counter : up-counter with clear/enable that saturates at LIMIT
// Rev 1.0
// ---------------------------------------------------------------------------
module sched_sat_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LIMIT   = 255,
  parameter bit          RST_SAT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic at_limit_o
);

  localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != c_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_SAT ? c_LIMIT : '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/sensor_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sensor_scheduler : rate-limited DHT11 read scheduler with response cache
// Optional feature macro: SCHED_CACHE_EN (serve fresh cached readings)
// Rev 1.0
// ---------------------------------------------------------------------------
module sensor_scheduler #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned MIN_GAP_CYC = 100000000,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_Req_Valid,
  input  logic [7:0] i_Req_Code,
  output logic       o_Req_Ready,
  output logic       o_Sens_En,
  input  logic       i_Sens_Done,
  input  logic       i_Sens_Error,
  input  logic [7:0] i_Hum_Int,
  input  logic [7:0] i_Hum_Float,
  input  logic [7:0] i_Temp_Int,
  input  logic [7:0] i_Temp_Float,
  output logic       o_Rsp_Valid,
  input  logic       i_Rsp_Ready,
  output logic [7:0] o_Rsp_Code,
  output logic [7:0] o_Rsp_Int,
  output logic [7:0] o_Rsp_Float
);

  import sensor_pkg::*;

  // Gap counter never narrower than a one-second count so the gap can be retuned.
  localparam int unsigned c_GAP_SPAN = (MIN_GAP_CYC > CLK_HZ) ? MIN_GAP_CYC : CLK_HZ;
  localparam int unsigned c_GAP_W    = $clog2(c_GAP_SPAN + 1);
  localparam int unsigned c_TO_W     = $clog2(TIMEOUT_CYC + 1);

  sched_state_e state_q;
  logic       req_ready_q, sens_en_q, rsp_valid_q;
  logic [7:0] rsp_code_q, rsp_int_q, rsp_float_q;
  logic [7:0] code_q;
  logic       cache_valid_q, last_error_q;

  logic       w_gap_sat, w_to_limit, w_start_read, w_fresh;
  logic [7:0] w_cache_int, w_cache_float, w_read_int, w_read_float;

  assign w_start_read = (state_q == ST_WAIT_GAP) && w_gap_sat;

  sched_sat_counter #(
    .WIDTH   (c_GAP_W),
    .LIMIT   (MIN_GAP_CYC),
    .RST_SAT (1'b1)
  ) u_gap_cnt (
    .clk_i      (i_Clock),
    .rst_i      (i_Rst),
    .clr_i      (w_start_read),
    .en_i       (1'b1),
    .at_limit_o (w_gap_sat)
  );

  sched_sat_counter #(
    .WIDTH   (c_TO_W),
    .LIMIT   (TIMEOUT_CYC - 1),
    .RST_SAT (1'b0)
  ) u_timeout_cnt (
    .clk_i      (i_Clock),
    .rst_i      (i_Rst),
    .clr_i      (w_start_read),
    .en_i       (state_q == ST_READ),
    .at_limit_o (w_to_limit)
  );

  assign w_read_int   = (code_q == c_REQ_TEMP) ? i_Temp_Int   : i_Hum_Int;
  assign w_read_float = (code_q == c_REQ_TEMP) ? i_Temp_Float : i_Hum_Float;

`ifdef SCHED_CACHE_EN
  logic [7:0] hum_int_q, hum_float_q, temp_int_q, temp_float_q;

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      hum_int_q    <= '0;
      hum_float_q  <= '0;
      temp_int_q   <= '0;
      temp_float_q <= '0;
    end else if ((state_q == ST_READ) && i_Sens_Done && !i_Sens_Error) begin
      hum_int_q    <= i_Hum_Int;
      hum_float_q  <= i_Hum_Float;
      temp_int_q   <= i_Temp_Int;
      temp_float_q <= i_Temp_Float;
    end
  end

  // Fresh means a good reading exists and the minimum gap has not yet elapsed.
  assign w_fresh       = cache_valid_q & ~w_gap_sat;
  assign w_cache_int   = (code_q == c_REQ_TEMP) ? temp_int_q   : hum_int_q;
  assign w_cache_float = (code_q == c_REQ_TEMP) ? temp_float_q : hum_float_q;
`else
  assign w_fresh       = 1'b0;
  assign w_cache_int   = '0;
  assign w_cache_float = '0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      sens_en_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= '0;
      rsp_int_q     <= '0;
      rsp_float_q   <= '0;
      code_q        <= '0;
      cache_valid_q <= 1'b0;
      last_error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_Req_Valid && req_ready_q) begin
            code_q      <= i_Req_Code;
            req_ready_q <= 1'b0;
            state_q     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (code_q == c_REQ_STATUS) begin
            rsp_code_q  <= c_REQ_STATUS;
            rsp_int_q   <= {7'b0, cache_valid_q};
            rsp_float_q <= {7'b0, last_error_q};
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (is_data_req(code_q)) begin
            if (w_fresh) begin
              rsp_code_q  <= code_q;
              rsp_int_q   <= w_cache_int;
              rsp_float_q <= w_cache_float;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              state_q <= ST_WAIT_GAP;
            end
          end else begin
            rsp_code_q  <= c_RSP_BADCODE;
            rsp_int_q   <= '0;
            rsp_float_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_WAIT_GAP: begin
          if (w_gap_sat) begin
            sens_en_q <= 1'b1;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          // Done wins over a timeout landing in the same cycle.
          if (i_Sens_Done) begin
            sens_en_q <= 1'b0;
            state_q   <= ST_CLEAR;
            if (i_Sens_Error) begin
              last_error_q  <= 1'b1;
              cache_valid_q <= 1'b0;
              rsp_code_q    <= c_RSP_CKSUM;
              rsp_int_q     <= '0;
              rsp_float_q   <= '0;
            end else begin
              last_error_q  <= 1'b0;
              cache_valid_q <= 1'b1;
              rsp_code_q    <= code_q;
              rsp_int_q     <= w_read_int;
              rsp_float_q   <= w_read_float;
            end
          end else if (w_to_limit) begin
            sens_en_q     <= 1'b0;
            state_q       <= ST_CLEAR;
            last_error_q  <= 1'b1;
            cache_valid_q <= 1'b0;
            rsp_code_q    <= c_RSP_TIMEOUT;
            rsp_int_q     <= '0;
            rsp_float_q   <= '0;
          end
        end
        ST_CLEAR: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_Rsp_Ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          sens_en_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Req_Ready = req_ready_q;
  assign o_Sens_En   = sens_en_q;
  assign o_Rsp_Valid = rsp_valid_q;
  assign o_Rsp_Code  = rsp_code_q;
  assign o_Rsp_Int   = rsp_int_q;
  assign o_Rsp_Float = rsp_float_q;

endmodule
`default_nettype wire

// File: doc/sensor_scheduler.md
SENSOR_SCHEDULER -- requirements
Module: sensor_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter MIN_GAP_CYC, default 100000000, minimum cycles between sensor read starts (2 s).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000000, maximum cycles a sensor read may take (1 s).
REQ-004 i_Clock  in  1  single clock; all logic on rising edge.
REQ-005 i_Rst  in  1  reset, synchronous, active-high.
REQ-006 i_Req_Valid  in  1  request byte present.
REQ-007 i_Req_Code  in  8  request code: 0x00 status, 0x02 temperature, 0x03 humidity.
REQ-008 o_Req_Ready  out  1  request accepted when Valid and Ready are both high.
REQ-009 o_Sens_En  out  1  level enable to the DHT11 interface.
REQ-010 i_Sens_Done  in  1  read-complete pulse from the interface.
REQ-011 i_Sens_Error  in  1  checksum or protocol error from the interface, sampled with Done.
REQ-012 i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float  in  8 each  sensor fields, valid with Done.
REQ-013 o_Rsp_Valid  out  1  response present; held until accepted.
REQ-014 i_Rsp_Ready  in  1  response consumer ready.
REQ-015 o_Rsp_Code, o_Rsp_Int, o_Rsp_Float  out  8 each  response code, integer byte, fraction byte.

Function
REQ-016 SHALL implement the states IDLE, DECODE, WAIT_GAP, READ, RESP and CLEAR.
REQ-017 IDLE SHALL drive o_Req_Ready=1; on handshake it SHALL register the code and go to DECODE; Ready SHALL be 0 in every other state.
REQ-018 DECODE, for code 0x00: SHALL go to RESP with Code 0x00, Int={7'b0, cache_valid}, Float={7'b0, last_error}.
REQ-019 DECODE, for code 0x02/0x03 with a fresh cache: SHALL go to RESP with cached data; the response SHALL be valid 2 cycles after the request handshake.
REQ-020 DECODE, for code 0x02/0x03 with no fresh cache: SHALL go to WAIT_GAP.
REQ-021 DECODE, for any other code: SHALL go to RESP with Code 0xEF, Int=0, Float=0.
REQ-022 gap_cnt SHALL reset to MIN_GAP_CYC (saturated), clear to 0 on entry to READ, and increment each cycle, saturating at MIN_GAP_CYC.
REQ-023 The cache SHALL be fresh iff cache_valid=1 and gap_cnt<MIN_GAP_CYC.
REQ-024 WAIT_GAP SHALL hold until gap_cnt==MIN_GAP_CYC, then go to READ in that same cycle.
REQ-025 READ SHALL drive o_Sens_En=1 and count timeout cycles from 0.
REQ-026 READ, on Done with Error=0: SHALL store all four fields, set cache_valid=1, clear last_error, and respond with the requested data.
REQ-027 READ, on Done with Error=1: SHALL set last_error, clear cache_valid, and respond with Code 0x1F, Int=0, Float=0.
REQ-028 READ, on the timeout count reaching TIMEOUT_CYC-1 with no Done: SHALL set last_error, clear cache_valid, and respond with Code 0x2F.
REQ-029 Done arriving in the same cycle as the timeout limit SHALL take priority over the timeout.
REQ-030 Every READ exit SHALL pass through CLEAR, which drives o_Sens_En=0 for exactly 1 cycle before RESP.
REQ-031 A data response SHALL carry Code equal to the request code; 0x02 returns the Temp fields and 0x03 returns the Hum fields.
REQ-032 RESP SHALL hold o_Rsp_Valid=1 with stable data until i_Rsp_Ready=1, then go to IDLE on the next cycle.
REQ-033 Done or Error arriving outside READ SHALL be ignored.

Reset
REQ-034 Reset SHALL force state IDLE and all outputs to 0, except o_Req_Ready=1.
REQ-035 Reset SHALL clear cache_valid, last_error and the timeout count, and saturate gap_cnt.
REQ-036 Reset asserted mid-READ SHALL drop o_Sens_En on the next edge, and no response SHALL be issued.

Configuration
REQ-037 With the macro SCHED_CACHE_EN defined: SHALL serve fresh-cache hits as in REQ-019.
REQ-038 With SCHED_CACHE_EN undefined: the cache SHALL never be fresh, so every data request goes through WAIT_GAP and READ.
REQ-039 With SCHED_CACHE_EN undefined: the status response SHALL still report cache_valid, and the gap enforcement SHALL be unchanged.

Structure
REQ-040 Package sensor_pkg SHALL hold the request codes (0x00/0x02/0x03), the response codes (0x1F/0x2F/0xEF) and the state enumeration.
REQ-041 gap_cnt and the timeout count SHALL be two instances of one sub-module, sched_sat_counter (clear, enable, saturating limit).

Verification
REQ-042 Reset, request 0x02, sensor Done after 1000 cycles with Temp 25/3 -> o_Sens_En high immediately, then response 0x02/25/3 held until Ready.
REQ-043 Request 0x03 100 cycles after a good read (cache enabled) -> response 0x03 from cache 2 cycles after handshake, o_Sens_En stays 0; with the macro off -> waits until MIN_GAP_CYC then reads.
REQ-044 Sensor never asserts Done -> response 0x2F after TIMEOUT_CYC cycles in READ, o_Sens_En low 1 cycle, then status reply 0x00/0/1.
REQ-045 Done with Error=1 -> response 0x1F; Done coincident with the timeout limit -> data response, not 0x2F.
REQ-046 Request 0x55 -> 0xEF/0/0; i_Rsp_Ready held low 10 cycles -> response stable; Req_Valid during RESP -> not accepted.
